// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, synchronous flush,
// and an optional second (skid) entry that makes in_ready a pure flop output.
module pipe_stage_reg #(
  parameter int DATA_W   = 96,
  parameter int CTRL_W   = 5,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding doubles as the entry count driven on occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_ready_q;
  logic              in_fire, out_fire;

  assign out_valid = (state != EMPTY);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = state;

  // With a skid entry the upstream sees only a flop; without one it sees the
  // downstream ready directly so a full stage still streams one entry per cycle.
  assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (in_fire) state_nxt = FULL1;
      FULL1: begin
        if (out_fire && !in_fire)      state_nxt = EMPTY;
        else if (in_fire && !out_fire) state_nxt = (SKID != 0) ? FULL2 : FULL1;
      end
      FULL2:   if (out_fire) state_nxt = FULL1;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // NOTE: payload registers are reset too, so out_data reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL2);
      if (flush) begin
        main_ctrl <= '0;
        skid_ctrl <= '0;
        skid_data <= '0;
        if (CLR_DATA != 0) main_data <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              main_data <= in_data;
              main_ctrl <= in_ctrl;
            end
          end
          FULL1: begin
            if (in_fire && out_fire) begin
              main_data <= in_data;
              main_ctrl <= in_ctrl;
            end else if (out_fire) begin
              main_ctrl <= '0;  // a bubble must never carry side-effect bits
            end else if (in_fire) begin
              skid_data <= in_data;
              skid_ctrl <= in_ctrl;
            end
          end
          FULL2: begin
            if (out_fire) begin
              main_data <= skid_data;
              main_ctrl <= skid_ctrl;
              skid_ctrl <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus randomized traffic checked
// against a queue model, on SKID=1/CLR_DATA=1, SKID=1/CLR_DATA=0 and SKID=0.
module tb_pipe_stage_reg;

  localparam int DW = 96;
  localparam int CW = 5;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } ent_t;

  logic clk;
  logic rst_n;

  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occ;

  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occ;

  logic          c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [CW-1:0] c_in_ctrl, c_out_ctrl;
  logic [DW-1:0] c_in_data, c_out_data;
  logic [1:0]    c_occ;

  int tests = 0;
  int fails = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLR_DATA(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLR_DATA(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CLR_DATA(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_ctrl(c_in_ctrl), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ctrl(c_out_ctrl), .out_data(c_out_data),
    .occupancy(c_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  ent_t qa[$];
  ent_t qc[$];
  ent_t e;
  logic c_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic exp_a_rdy, exp_c_rdy, a_if, a_of, c_if, c_of;
  int   c_in_cnt = 0;
  int   c_out_cnt = 0;

  initial begin
    {a_flush, a_in_valid, a_out_ready, a_in_ctrl, a_in_data} = '0;
    {b_flush, b_in_valid, b_out_ready, b_in_ctrl, b_in_data} = '0;
    {c_flush, c_in_valid, c_out_ready, c_in_ctrl, c_in_data} = '0;

    // Reset values
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_occupancy", a_occ, 0);
    check("rst_out_ctrl", a_out_ctrl, 0);
    check("rst_out_data", a_out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_in_ready", a_in_ready, 1);

    // Stream 1..5 with out_ready held high
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_in_data = DW'(i); a_in_ctrl = 5'b10101; a_out_ready = 1'b1;
      @(posedge clk); #1;
      check("stream_valid", a_out_valid, 1);
      check("stream_data", a_out_data, DW'(i));
      check("stream_ctrl", a_out_ctrl, 5'b10101);
      check("stream_occ", a_occ, 1);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_drain_valid", a_out_valid, 0);
    check("stream_drain_ctrl", a_out_ctrl, 0);
    check("stream_drain_occ", a_occ, 0);

    // Backpressure into the skid entry
    @(negedge clk);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 'hA;
    @(negedge clk);
    a_in_data = 'hB;
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    check("bp_occ", a_occ, 2);
    check("bp_in_ready", a_in_ready, 0);
    check("bp_data", a_out_data, 'hA);
    @(negedge clk);
    check("bp_hold_data", a_out_data, 'hA);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_second_data", a_out_data, 'hB);
    check("bp_ready_back", a_in_ready, 1);
    check("bp_second_occ", a_occ, 1);
    @(posedge clk); #1;
    check("bp_empty", a_out_valid, 0);

    // Flush from FULL2 beats a concurrent input
    @(negedge clk);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 'hA;
    @(negedge clk);
    a_in_data = 'hB;
    @(negedge clk);
    a_flush = 1'b1; a_in_data = 'hC;
    @(posedge clk); #1;
    check("flush_valid", a_out_valid, 0);
    check("flush_ctrl", a_out_ctrl, 0);
    check("flush_occ", a_occ, 0);
    check("flush_data", a_out_data, 0);
    check("flush_in_ready", a_in_ready, 1);
    @(negedge clk);
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(posedge clk); #1;
    check("flush_no_c", a_out_valid, 0);

    // CLR_DATA=0: flush keeps the payload, clears valid and ctrl
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = 'h55; b_in_ctrl = 5'b11111; b_out_ready = 1'b0;
    @(posedge clk); #1;
    check("hold_valid", b_out_valid, 1);
    check("hold_data", b_out_data, 'h55);
    @(negedge clk);
    b_in_valid = 1'b0; b_flush = 1'b1;
    @(posedge clk); #1;
    check("hold_flush_valid", b_out_valid, 0);
    check("hold_flush_ctrl", b_out_ctrl, 0);
    check("hold_flush_data", b_out_data, 'h55);
    @(negedge clk);
    b_flush = 1'b0;

    // Async reset between edges while holding two entries
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 'h11; a_in_ctrl = 5'b00011;
    @(negedge clk);
    a_in_data = 'h22;
    @(negedge clk);
    a_in_valid = 1'b0;
    #1 check("arst_pre_occ", a_occ, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", a_out_valid, 0);
    check("arst_occ", a_occ, 0);
    check("arst_ctrl", a_out_ctrl, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_in_valid = 1'b1; a_in_data = 'h77; a_out_ready = 1'b1;
    @(posedge clk); #1;
    check("arst_first_valid", a_out_valid, 1);
    check("arst_first_data", a_out_data, 'h77);
    @(negedge clk);
    a_in_valid = 1'b0;
    @(posedge clk);

    // Randomized traffic against queue models (A: SKID=1, C: SKID=0)
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_out_ready = 1'($urandom_range(0, 1));
      a_flush     = ($urandom_range(0, 24) == 0);
      a_in_data   = {$urandom, $urandom, $urandom};
      a_in_ctrl   = CW'($urandom);
      c_in_valid  = (cyc < 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
      c_out_ready = (cyc < 6) ? c_pat[cyc] : 1'($urandom_range(0, 1));
      c_in_data   = {$urandom, $urandom, $urandom};
      c_in_ctrl   = CW'($urandom);
      #1;
      exp_a_rdy = (qa.size() < 2);
      exp_c_rdy = (qc.size() == 0) || c_out_ready;
      check("rnd_a_in_ready", a_in_ready, exp_a_rdy);
      check("rnd_a_valid", a_out_valid, qa.size() != 0);
      check("rnd_a_occ", a_occ, qa.size());
      check("rnd_a_ctrl", a_out_ctrl, (qa.size() != 0) ? qa[0].ctrl : '0);
      if (qa.size() != 0) check("rnd_a_data", a_out_data, qa[0].data);
      check("rnd_c_in_ready", c_in_ready, exp_c_rdy);
      check("rnd_c_valid", c_out_valid, qc.size() != 0);
      check("rnd_c_occ", c_occ, qc.size());
      check("rnd_c_ctrl", c_out_ctrl, (qc.size() != 0) ? qc[0].ctrl : '0);
      if (qc.size() != 0) check("rnd_c_data", c_out_data, qc[0].data);
      if (c_in_valid && c_in_ready) c_in_cnt++;
      if (c_out_valid && c_out_ready) c_out_cnt++;
      a_if = a_in_valid && exp_a_rdy;
      a_of = (qa.size() != 0) && a_out_ready;
      c_if = c_in_valid && exp_c_rdy;
      c_of = (qc.size() != 0) && c_out_ready;
      @(posedge clk);
      if (a_flush) begin
        qa.delete();
      end else begin
        if (a_of) void'(qa.pop_front());
        if (a_if) begin e.ctrl = a_in_ctrl; e.data = a_in_data; qa.push_back(e); end
      end
      if (c_of) void'(qc.pop_front());
      if (c_if) begin e.ctrl = c_in_ctrl; e.data = c_in_data; qc.push_back(e); end
    end

    // Drain and compare entry counts through the SKID=0 stage
    @(negedge clk);
    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
    c_in_valid = 1'b0; c_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (c_out_valid && c_out_ready) c_out_cnt++;
      @(negedge clk);
    end
    check("drain_a_valid", a_out_valid, 0);
    check("drain_c_valid", c_out_valid, 0);
    check("c_scoreboard_count", c_out_cnt, c_in_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
